// File: rtl/cam_pkg.sv
// Shared camera-capture constants and the capture FSM state type. The frame-buffer
// reader imports the same package, so both sides agree on geometry and address width.
package cam_pkg;

    localparam int H_RES  = 320;
    localparam int V_RES  = 240;
    localparam int ADDR_W = $clog2(H_RES * V_RES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        CAPTURE
    } cap_state_t;

endpackage

// File: rtl/cam_byte_packer.sv
// Packs consecutive camera bytes into one RGB565 word: the first byte of a pixel
// goes to [15:8] and the second byte to [7:0]. The valid pulse marks the second byte.
module cam_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        href,
    input  logic [7:0]  data,
    input  logic        phase,
    output logic [15:0] word,
    output logic        valid
);

    logic [7:0] hi;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
        end else if (href && !phase) begin
            hi <= data;
        end
    end

    assign word  = {hi, data};
    assign valid = href & phase;

endmodule

// File: rtl/ov7670_frame_capture.sv
// OV7670 parallel-bus capture into a linear RGB565 frame buffer (addr = y*H_RES + x).
// Define OV7670_CAP_STATS_EN to enable the frame counter and line-length checker.
module ov7670_frame_capture #(
    parameter int H_RES  = cam_pkg::H_RES,
    parameter int V_RES  = cam_pkg::V_RES,
    parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              line_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    cam_pkg::cap_state_t state, next_state;

    logic              vsync_q;
    logic              vsync_rise;
    logic              vsync_fall;
    logic              frame_start;
    logic              frame_end;
    logic              byte_ok;
    logic              phase;
    logic              full;
    logic [ADDR_W-1:0] pix_addr;
    logic [15:0]       pix_word;
    logic              pix_valid;

    assign vsync_rise = vsync & ~vsync_q;
    assign vsync_fall = ~vsync & vsync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= cam_pkg::IDLE;
            vsync_q <= 1'b0;
        end else begin
            state   <= next_state;
            vsync_q <= vsync;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        byte_ok     = 1'b0;
        case (state)
            cam_pkg::IDLE: begin
                if (capture_en) next_state = cam_pkg::WAIT_FRAME;
            end
            cam_pkg::WAIT_FRAME: begin
                if (vsync_fall) begin
                    frame_start = 1'b1;
                    next_state  = cam_pkg::CAPTURE;
                end
            end
            cam_pkg::CAPTURE: begin
                // A byte coinciding with the vsync edge belongs to no frame and is dropped.
                byte_ok = href & ~vsync_rise;
                if (vsync_rise) begin
                    frame_end  = 1'b1;
                    next_state = capture_en ? cam_pkg::WAIT_FRAME : cam_pkg::IDLE;
                end
            end
            default: next_state = cam_pkg::IDLE;
        endcase
    end

    cam_byte_packer u_packer (
        .clk   (clk),
        .reset (reset),
        .href  (byte_ok),
        .data  (data),
        .phase (phase),
        .word  (pix_word),
        .valid (pix_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we         <= 1'b0;
            wAddr      <= '0;
            wData      <= '0;
            frame_done <= 1'b0;
            phase      <= 1'b0;
            full       <= 1'b0;
            pix_addr   <= '0;
        end else begin
            we         <= 1'b0;
            frame_done <= frame_end;
            if (frame_start) begin
                phase    <= 1'b0;
                full     <= 1'b0;
                pix_addr <= '0;
            end else if (byte_ok) begin
                phase <= ~phase;
                // Once the last buffer location is written the address freezes; no wrap.
                if (pix_valid && !full) begin
                    we    <= 1'b1;
                    wAddr <= pix_addr;
                    wData <= pix_word;
                    if (pix_addr == LAST_ADDR) full <= 1'b1;
                    else                       pix_addr <= pix_addr + 1'b1;
                end
            end else begin
                phase <= 1'b0;
            end
        end
    end

`ifdef OV7670_CAP_STATS_EN
    localparam int LCNT_W = $clog2(H_RES + 2);

    logic              href_q;
    logic [LCNT_W-1:0] line_cnt;

    // Counts started pixels, so an odd trailing byte makes the line look one pixel long.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            href_q    <= 1'b0;
            line_cnt  <= '0;
            frame_cnt <= '0;
            line_err  <= 1'b0;
        end else begin
            href_q <= href;
            if (frame_end) frame_cnt <= frame_cnt + 8'd1;
            if (frame_start) begin
                line_cnt <= '0;
                line_err <= 1'b0;
            end else if (state == cam_pkg::CAPTURE) begin
                if (href_q && !href) begin
                    if (line_cnt != LCNT_W'(H_RES)) line_err <= 1'b1;
                    line_cnt <= '0;
                end else if (byte_ok && !phase && line_cnt != '1) begin
                    line_cnt <= line_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign frame_cnt = '0;
    assign line_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Randomized scoreboard bench for ov7670_frame_capture on a reduced 8x4 frame;
// honours OV7670_CAP_STATS_EN for the frame counter and line-error expectations.
module tb_ov7670_frame_capture;

    localparam int TH    = 8;
    localparam int TV    = 4;
    localparam int TOTAL = TH * TV;
    localparam int TA    = $clog2(TOTAL);
`ifdef OV7670_CAP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          capture_en = 1'b0;
    logic          vsync = 1'b1;
    logic          href = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          we;
    logic [TA-1:0] wAddr;
    logic [15:0]   wData;
    logic          frame_done;
    logic [7:0]    frame_cnt;
    logic          line_err;

    typedef struct {
        int addr;
        int word;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  m_frame_cnt = 0;
    bit  m_line_err = 1'b0;

    ov7670_frame_capture #(.H_RES(TH), .V_RES(TV), .ADDR_W(TA)) dut (
        .clk        (clk),
        .reset      (reset),
        .capture_en (capture_en),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .we         (we),
        .wAddr      (wAddr),
        .wData      (wData),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .line_err   (line_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_we"},         we,         0);
        check({tag, "_wAddr"},      wAddr,      0);
        check({tag, "_wData"},      wData,      0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_cnt"},  frame_cnt,  0);
        check({tag, "_line_err"},   line_err,   0);
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected pixel.
    always @(negedge clk) begin
        if (we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", int'(wAddr), -1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("w_addr", int'(wAddr), e.addr);
                check("w_data", int'(wData), e.word);
            end
        end
    end

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        @(posedge clk);
        #1;
        vsync = v;
        href  = h;
        data  = d;
    endtask

    // One camera frame. Negative option values disable that option:
    // odd_line gets one extra byte, en_off_line drops capture_en, rst_pix resets
    // on that pixel's second byte, cut_byte raises vsync together with that byte
    // of the last line.
    task automatic run_frame(input int n_lines, input int odd_line, input int en_off_line,
                             input int rst_pix, input int cut_byte);
        bit         cap;
        bit         killed;
        bit         cut;
        int         addr;
        int         rst_left;
        int         nbytes;
        int         starts;
        logic [7:0] hi;
        logic [7:0] d;
        wr_t        e;

        cap      = capture_en;
        killed   = 1'b0;
        cut      = 1'b0;
        addr     = 0;
        rst_left = 0;
        hi       = 8'h00;
        if (cap) m_line_err = 1'b0;

        repeat (4) drive(1'b1, 1'b0, 8'h00);
        repeat (2) drive(1'b0, 1'b0, 8'h00);

        for (int l = 0; l < n_lines && !cut; l++) begin
            nbytes = 2 * TH + ((l == odd_line) ? 1 : 0);
            starts = 0;
            for (int b = 0; b < nbytes; b++) begin
                d = 8'($urandom);
                if (l == en_off_line && b == 0) capture_en = 1'b0;
                if (cut_byte >= 0 && l == n_lines - 1 && b == cut_byte) begin
                    drive(1'b1, 1'b1, d);
                    cut = 1'b1;
                    break;
                end
                drive(1'b0, 1'b1, d);
                if (rst_left > 0) begin
                    rst_left--;
                    if (rst_left == 0) reset = 1'b0;
                end else if (!killed && cap && (b % 2 == 1) && addr == rst_pix) begin
                    reset       = 1'b1;
                    killed      = 1'b1;
                    rst_left    = 3;
                    m_frame_cnt = 0;
                    m_line_err  = 1'b0;
                    #1;
                    check_zero_outputs("mid_reset");
                end
                if (cap && !killed) begin
                    if (b % 2 == 0) begin
                        hi = d;
                        starts++;
                    end else begin
                        if (addr < TOTAL) begin
                            e.addr = addr;
                            e.word = int'({hi, d});
                            exp_q.push_back(e);
                        end
                        addr++;
                    end
                end
            end
            if (!cut) begin
                repeat (1 + $urandom_range(1, 3)) drive(1'b0, 1'b0, 8'h00);
                if (cap && !killed && starts != TH) m_line_err = 1'b1;
            end
        end

        if (rst_left > 0) begin
            repeat (rst_left) drive(1'b0, 1'b0, 8'h00);
            reset = 1'b0;
        end

        if (!cut) drive(1'b1, 1'b0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check("frame_done", frame_done, int'(cap && !killed));
        @(negedge clk);
        check("frame_done_width", frame_done, 0);
        if (cap && !killed) m_frame_cnt++;
        check("frame_cnt", frame_cnt, STATS ? (m_frame_cnt % 256) : 0);
        check("line_err", line_err, STATS ? int'(m_line_err) : 0);
        check("pending_writes", exp_q.size(), 0);
        if (cap && !killed && addr > 0)
            check("w_addr_hold", int'(wAddr), ((addr < TOTAL) ? addr : TOTAL) - 1);
        drive(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        reset      = 1'b0;
        capture_en = 1'b1;

        run_frame(TV,     -1, -1, -1, -1);  // plain frame
        run_frame(TV,      1, -1, -1, -1);  // odd trailing byte on line 1
        run_frame(TV + 1, -1, -1, -1, -1);  // one line too many: address saturates
        run_frame(TV,     -1,  2, -1, -1);  // capture_en dropped mid-frame
        run_frame(TV,     -1, -1, -1, -1);  // idle: no writes expected
        capture_en = 1'b1;
        run_frame(TV,     -1, -1, 13, -1);  // reset mid-line
        run_frame(TV,     -1, -1, -1, -1);  // restarts at address 0
        run_frame(TV,     -1, -1, -1,  5);  // vsync edge coincides with a byte
        run_frame(2,      -1, -1, -1, -1);  // short frame
        for (int i = 0; i < 4; i++)
            run_frame(int'($urandom_range(2, TV + 1)), int'($urandom_range(0, TV + 1)) - 1,
                      -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
